// File: rtl/mac_pkg.sv
// Shared definitions for the MAC array accumulator: operand modes, FSM states
// and the saturating accumulate helper.
package mac_pkg;

  localparam logic [1:0] MODE_INT8 = 2'd0;
  localparam logic [1:0] MODE_INT4 = 2'd1;

  // Wide enough to hold any old + dot sum without wrapping before clipping.
  localparam int SUM_W = 64;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DRAIN_WAIT,
    DRAIN
  } state_t;

  typedef struct packed {
    logic             sat;
    logic [SUM_W-1:0] val;
  } sat_res_t;

  // Add two sign-extended operands and clip to a signed acc_w-bit range.
  function automatic sat_res_t sat_add(input logic signed [SUM_W-1:0] a,
                                       input logic signed [SUM_W-1:0] b,
                                       input int                      acc_w);
    logic signed [SUM_W-1:0] sum;
    logic signed [SUM_W-1:0] hi;
    logic signed [SUM_W-1:0] lo;
    sat_res_t                res;
    sum     = a + b;
    hi      = (64'sd1 <<< (acc_w - 1)) - 64'sd1;
    lo      = -(64'sd1 <<< (acc_w - 1));
    res.sat = 1'b0;
    res.val = sum;
    if (sum > hi) begin
      res.val = hi;
      res.sat = 1'b1;
    end else if (sum < lo) begin
      res.val = lo;
      res.sat = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/mac_array_acc_if.sv
// Operand, drain and status signals of the MAC array accumulator.
interface mac_array_acc_if #(
  parameter int N_LANES   = 16,
  parameter int N_ELEM    = 32,
  parameter int ACC_DEPTH = 16,
  parameter int ACC_W     = 24
);
  localparam int AW = $clog2(ACC_DEPTH);

  logic                        in_valid;
  logic                        in_ready;
  logic [1:0]                  in_mode;
  logic [AW-1:0]               in_addr;
  logic                        in_first;
  logic [N_LANES*N_ELEM*8-1:0] a_vec;
  logic [N_ELEM*8-1:0]         b_vec;
  logic                        drain_req;
  logic                        out_valid;
  logic                        out_ready;
  logic [AW-1:0]               out_addr;
  logic [N_LANES*ACC_W-1:0]    out_data;
  logic                        sat_flag;
  logic                        mode_err;
  logic                        busy;

  modport master (
    output in_valid, in_mode, in_addr, in_first, a_vec, b_vec, drain_req, out_ready,
    input  in_ready, out_valid, out_addr, out_data, sat_flag, mode_err, busy
  );

  modport slave (
    input  in_valid, in_mode, in_addr, in_first, a_vec, b_vec, drain_req, out_ready,
    output in_ready, out_valid, out_addr, out_data, sat_flag, mode_err, busy
  );
endinterface

// File: rtl/mac_lane_dot.sv
// Combinational signed dot product of one lane's A vector against B,
// as N_ELEM INT8 products or 2*N_ELEM INT4 products; reserved modes give 0.
module mac_lane_dot
  import mac_pkg::*;
#(
  parameter int N_ELEM = 32,
  parameter int DOT_W  = 17 + $clog2(N_ELEM)
) (
  input  logic [1:0]              mode,
  input  logic [N_ELEM*8-1:0]     a,
  input  logic [N_ELEM*8-1:0]     b,
  output logic signed [DOT_W-1:0] dot
);

  // Sum all element products at full width for the selected mode.
  always_comb begin
    logic signed [15:0] p8;
    logic signed [7:0]  p4_lo;
    logic signed [7:0]  p4_hi;
    // NOTE: every combinational variable gets a default before any branch so no latch is inferred.
    dot   = '0;
    p8    = '0;
    p4_lo = '0;
    p4_hi = '0;
    for (int i = 0; i < N_ELEM; i++) begin
      if (mode == MODE_INT8) begin
        p8  = 16'($signed(a[i*8 +: 8])) * 16'($signed(b[i*8 +: 8]));
        dot = dot + DOT_W'(p8);
      end else if (mode == MODE_INT4) begin
        p4_lo = 8'($signed(a[i*8 +: 4])) * 8'($signed(b[i*8 +: 4]));
        p4_hi = 8'($signed(a[i*8+4 +: 4])) * 8'($signed(b[i*8+4 +: 4]));
        dot   = dot + DOT_W'(p4_lo) + DOT_W'(p4_hi);
      end
    end
  end

endmodule

// File: rtl/mac_array_acc.sv
// N_LANES-wide MAC array: two-stage dot/accumulate pipeline into a
// per-lane saturating partial-sum buffer, drained through a valid/ready port.
module mac_array_acc
  import mac_pkg::*;
#(
  parameter int N_LANES   = 16,
  parameter int N_ELEM    = 32,
  parameter int ACC_DEPTH = 16,
  parameter int ACC_W     = 24
) (
  input logic            clk,
  input logic            rst,
  mac_array_acc_if.slave bus
);

  localparam int            AW        = $clog2(ACC_DEPTH);
  localparam int            DOT_W     = 17 + $clog2(N_ELEM);
  localparam logic [AW-1:0] LAST_ADDR = AW'(ACC_DEPTH - 1);

  state_t state, next_state;
  logic   in_ready_q;
  logic   accept, pipe_empty, drain_start, drain_hs, drain_last;

  logic signed [DOT_W-1:0] lane_dot [N_LANES];

  logic                    s1_valid, s1_first;
  logic [AW-1:0]           s1_addr;
  logic signed [DOT_W-1:0] s1_dot [N_LANES];

  logic                    s2_valid;
  logic [AW-1:0]           s2_addr;
  logic signed [ACC_W-1:0] s2_val  [N_LANES];
  logic signed [ACC_W-1:0] s2_next [N_LANES];
  logic                    s2_sat_next;

  logic signed [ACC_W-1:0] acc_mem [N_LANES][ACC_DEPTH];

  logic                     out_valid_q;
  logic [AW-1:0]            out_addr_q;
  logic [N_LANES*ACC_W-1:0] out_data_q;
  logic                     sat_q, mode_err_q;

  for (genvar l = 0; l < N_LANES; l++) begin : g_lane
    mac_lane_dot #(.N_ELEM(N_ELEM), .DOT_W(DOT_W)) u_dot (
      .mode (bus.in_mode),
      .a    (bus.a_vec[l*N_ELEM*8 +: N_ELEM*8]),
      .b    (bus.b_vec),
      .dot  (lane_dot[l])
    );
  end

  assign accept      = bus.in_valid & in_ready_q;
  assign pipe_empty  = ~s1_valid & ~s2_valid;
  assign drain_start = (state == DRAIN_WAIT) & pipe_empty;
  assign drain_hs    = out_valid_q & bus.out_ready;
  assign drain_last  = drain_hs & (out_addr_q == LAST_ADDR);

  // State register; in_ready follows the state being entered.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state      <= IDLE;
      in_ready_q <= 1'b0;
    end else begin
      state      <= next_state;
      in_ready_q <= (next_state == IDLE) | (next_state == ACCUM);
    end
  end

  // Next-state logic: drain_req wins over a same-cycle beat, which still lands in the drain.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:       if (bus.drain_req) next_state = DRAIN_WAIT;
                  else if (accept)   next_state = ACCUM;
      ACCUM:      if (bus.drain_req) next_state = DRAIN_WAIT;
      DRAIN_WAIT: if (pipe_empty)    next_state = DRAIN;
      DRAIN:      if (drain_last)    next_state = IDLE;
      default:                       next_state = IDLE;
    endcase
  end

  // Partial-sum buffer: S2 writeback, or clear-on-read during drain.
  always_ff @(posedge clk) begin
    // NOTE: the buffer is flops and must read back zero after reset, so every entry is reset;
    // pure datapath registers qualified by a valid bit are left without reset.
    if (rst) begin
      for (int l = 0; l < N_LANES; l++)
        for (int e = 0; e < ACC_DEPTH; e++)
          acc_mem[l][e] <= '0;
    end else if (s2_valid) begin
      for (int l = 0; l < N_LANES; l++) acc_mem[l][s2_addr] <= s2_val[l];
    end else if (drain_hs) begin
      for (int l = 0; l < N_LANES; l++) acc_mem[l][out_addr_q] <= '0;
    end
  end

  // S1 control: registers the accepted beat's address and overwrite flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_addr  <= '0;
      s1_first <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_addr  <= bus.in_addr;
        s1_first <= bus.in_first;
      end
    end
  end

  // S1 data: lane dot products.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int l = 0; l < N_LANES; l++) s1_dot[l] <= lane_dot[l];
    end
  end

  // S2 read-add-saturate, forwarding the in-flight S2 result on an address match.
  always_comb begin
    logic signed [ACC_W-1:0] old_v;
    sat_res_t                res;
    logic                    fwd;
    s2_sat_next = 1'b0;
    old_v       = '0;
    res         = '0;
    fwd         = s2_valid & (s2_addr == s1_addr);
    for (int l = 0; l < N_LANES; l++) begin
      old_v = fwd ? s2_val[l] : acc_mem[l][s1_addr];
      if (s1_first) old_v = '0;
      res         = sat_add(SUM_W'(old_v), SUM_W'(s1_dot[l]), ACC_W);
      s2_next[l]  = res.val[ACC_W-1:0];
      s2_sat_next = s2_sat_next | res.sat;
    end
  end

  // S2 control: valid and target entry of the pending write.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_addr  <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) s2_addr <= s1_addr;
    end
  end

  // S2 data: saturated sums waiting to be written.
  always_ff @(posedge clk) begin
    if (s1_valid) begin
      for (int l = 0; l < N_LANES; l++) s2_val[l] <= s2_next[l];
    end
  end

  // Sticky status flags, cleared by the last drain handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_q      <= 1'b0;
      mode_err_q <= 1'b0;
    end else if (drain_last) begin
      sat_q      <= 1'b0;
      mode_err_q <= 1'b0;
    end else begin
      if (s1_valid & s2_sat_next)  sat_q      <= 1'b1;
      if (accept & bus.in_mode[1]) mode_err_q <= 1'b1;
    end
  end

  // Registered drain port: load entry 0, then advance on each handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
    end else if (drain_start) begin
      out_valid_q <= 1'b1;
      out_addr_q  <= '0;
      for (int l = 0; l < N_LANES; l++) out_data_q[l*ACC_W +: ACC_W] <= acc_mem[l][0];
    end else if (drain_hs) begin
      if (out_addr_q == LAST_ADDR) begin
        out_valid_q <= 1'b0;
        out_addr_q  <= '0;
      end else begin
        out_addr_q <= out_addr_q + 1'b1;
        for (int l = 0; l < N_LANES; l++)
          out_data_q[l*ACC_W +: ACC_W] <= acc_mem[l][out_addr_q + 1'b1];
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.out_data  = out_data_q;
  assign bus.sat_flag  = sat_q;
  assign bus.mode_err  = mode_err_q;
  assign bus.busy      = (state != IDLE) | s1_valid | s2_valid;

endmodule

// File: tb/tb_mac_array_acc.sv
// Self-checking bench for mac_array_acc: directed and random beats scored
// against an arithmetic reference buffer, checked through the drain port.
module tb_mac_array_acc;

  localparam int N_LANES   = 16;
  localparam int N_ELEM    = 32;
  localparam int ACC_DEPTH = 16;
  localparam int ACC_W     = 24;
  localparam int A_W       = N_LANES * N_ELEM * 8;
  localparam int B_W       = N_ELEM * 8;
  localparam longint ACC_MAX = (64'sd1 <<< (ACC_W - 1)) - 1;
  localparam longint ACC_MIN = -(64'sd1 <<< (ACC_W - 1));

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mac_array_acc_if #(.N_LANES(N_LANES), .N_ELEM(N_ELEM), .ACC_DEPTH(ACC_DEPTH), .ACC_W(ACC_W)) bus ();

  mac_array_acc #(.N_LANES(N_LANES), .N_ELEM(N_ELEM), .ACC_DEPTH(ACC_DEPTH), .ACC_W(ACC_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int     checks = 0;
  int     errors = 0;
  longint model_mem [N_LANES][ACC_DEPTH];
  bit     model_sat, model_err;
  longint drained [ACC_DEPTH][N_LANES];

  // ---------------- reference model ----------------
  function automatic int sx8(input logic [7:0] v);
    int x = int'(v);
    if (x > 127) x = x - 256;
    return x;
  endfunction

  function automatic int sx4(input logic [3:0] v);
    int x = int'(v);
    if (x > 7) x = x - 16;
    return x;
  endfunction

  function automatic longint model_dot(input logic [1:0] mode, input logic [B_W-1:0] a,
                                       input logic [B_W-1:0] b);
    longint s = 0;
    logic [7:0] ab, bb;
    if (mode > 2'd1) return 0;
    for (int i = 0; i < N_ELEM; i++) begin
      ab = a[i*8 +: 8];
      bb = b[i*8 +: 8];
      if (mode == 2'd0) s = s + sx8(ab) * sx8(bb);
      else s = s + sx4(ab[3:0]) * sx4(bb[3:0]) + sx4(ab[7:4]) * sx4(bb[7:4]);
    end
    return s;
  endfunction

  task automatic model_accept(input logic [1:0] mode, input int addr, input bit first,
                              input logic [A_W-1:0] a, input logic [B_W-1:0] b);
    longint v;
    for (int l = 0; l < N_LANES; l++) begin
      v = (first ? 0 : model_mem[l][addr]) + model_dot(mode, a[l*B_W +: B_W], b);
      if (v > ACC_MAX) begin v = ACC_MAX; model_sat = 1'b1; end
      if (v < ACC_MIN) begin v = ACC_MIN; model_sat = 1'b1; end
      model_mem[l][addr] = v;
    end
    if (mode > 2'd1) model_err = 1'b1;
  endtask

  task automatic model_clear();
    for (int l = 0; l < N_LANES; l++)
      for (int e = 0; e < ACC_DEPTH; e++) model_mem[l][e] = 0;
    model_sat = 1'b0;
    model_err = 1'b0;
  endtask

  function automatic bit entry_is(input int e, input longint v);
    for (int l = 0; l < N_LANES; l++) if (drained[e][l] != v) return 1'b0;
    return 1'b1;
  endfunction

  // ---------------- drivers ----------------
  task automatic rand_operands(output logic [A_W-1:0] a, output logic [B_W-1:0] b);
    for (int i = 0; i < N_LANES * N_ELEM; i++) a[i*8 +: 8] = 8'($urandom);
    for (int i = 0; i < N_ELEM; i++) b[i*8 +: 8] = 8'($urandom);
  endtask

  // Present one beat at a negedge; it is accepted at the following posedge.
  task automatic beat(input logic [1:0] mode, input int addr, input bit first,
                      input logic [A_W-1:0] a, input logic [B_W-1:0] b, input bit with_drain);
    int w = 0;
    while (bus.in_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL beat_ready: in_ready=%b required 1", bus.in_ready);
      return;
    end
    bus.in_valid  = 1'b1;
    bus.in_mode   = mode;
    bus.in_addr   = 4'(addr);
    bus.in_first  = first;
    bus.a_vec     = a;
    bus.b_vec     = b;
    bus.drain_req = with_drain;
    model_accept(mode, addr, first, a, b);
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.drain_req = 1'b0;
  endtask

  // Drain all entries; ready_mode 0=always, 1=pattern 1,0,0,1, 2=random.
  // abort_at >= 0 asserts rst while that entry is presented and returns.
  task automatic drain(input int ready_mode, input int abort_at);
    int idx = 0;
    int cyc = 0;
    int k   = 0;
    bit rdy;
    logic [N_LANES*ACC_W-1:0] exp_data;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.sat_flag !== model_sat) begin
      errors++;
      $display("FAIL pre_drain_sat: sat_flag=%b required %b", bus.sat_flag, model_sat);
    end
    checks++;
    if (bus.mode_err !== model_err) begin
      errors++;
      $display("FAIL pre_drain_mode_err: mode_err=%b required %b", bus.mode_err, model_err);
    end
    bus.drain_req = 1'b1;
    @(negedge clk);
    bus.drain_req = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL drain_in_ready_drop: in_ready=%b required 0", bus.in_ready);
    end
    while (idx < ACC_DEPTH && cyc < 400) begin
      if (bus.out_valid === 1'b1) begin
        for (int l = 0; l < N_LANES; l++) exp_data[l*ACC_W +: ACC_W] = ACC_W'(model_mem[l][idx]);
        checks++;
        if (bus.out_addr !== 4'(idx)) begin
          errors++;
          $display("FAIL drain_addr: out_addr=%0d required %0d", bus.out_addr, idx);
        end
        checks++;
        if (bus.out_data !== exp_data) begin
          errors++;
          $display("FAIL drain_data[%0d]: out_data=%h required %h", idx, bus.out_data, exp_data);
        end
        checks++;
        if (bus.in_ready !== 1'b0) begin
          errors++;
          $display("FAIL drain_in_ready: in_ready=%b required 0 at entry %0d", bus.in_ready, idx);
        end
        if (idx == abort_at) begin
          rst           = 1'b1;
          bus.out_ready = 1'b0;
          return;
        end
        case (ready_mode)
          0:       rdy = 1'b1;
          1:       rdy = (k % 4 == 0) || (k % 4 == 3);
          default: rdy = 1'($urandom_range(1, 0));
        endcase
        k++;
        bus.out_ready = rdy;
        if (rdy) begin
          for (int l = 0; l < N_LANES; l++) begin
            drained[idx][l]   = longint'($signed(bus.out_data[l*ACC_W +: ACC_W]));
            model_mem[l][idx] = 0;
          end
          idx++;
        end
      end else begin
        bus.out_ready = 1'($urandom_range(1, 0));
      end
      @(negedge clk);
      cyc++;
    end
    bus.out_ready = 1'b0;
    checks++;
    if (idx != ACC_DEPTH) begin
      errors++;
      $display("FAIL drain_timeout: handshakes=%0d required %0d", idx, ACC_DEPTH);
    end
    checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL drain_end: out_valid=%b busy=%b required 0 0", bus.out_valid, bus.busy);
    end
    checks++;
    if (bus.sat_flag !== 1'b0 || bus.mode_err !== 1'b0) begin
      errors++;
      $display("FAIL drain_flag_clear: sat_flag=%b mode_err=%b required 0 0", bus.sat_flag, bus.mode_err);
    end
    model_sat = 1'b0;
    model_err = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: in_ready=%b out_valid=%b busy=%b required 0 0 0",
               bus.in_ready, bus.out_valid, bus.busy);
    end
    checks++;
    if (bus.out_addr !== '0 || bus.out_data !== '0) begin
      errors++;
      $display("FAIL reset_data: out_addr=%0d out_data=%h required 0 0", bus.out_addr, bus.out_data);
    end
    checks++;
    if (bus.sat_flag !== 1'b0 || bus.mode_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: sat_flag=%b mode_err=%b required 0 0", bus.sat_flag, bus.mode_err);
    end
    rst = 1'b0;
    model_clear();
  endtask

  task automatic test_int8_basic();
    beat(2'd0, 0, 1'b1, {(A_W/8){8'h02}}, {(B_W/8){8'h03}}, 1'b0);
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL int8_busy: busy=%b required 1", bus.busy);
    end
    drain(0, -1);
    checks++;
    if (!entry_is(0, 192)) begin
      errors++;
      $display("FAIL int8_entry0: lane0=%0d required 192", drained[0][0]);
    end
    for (int e = 1; e < ACC_DEPTH; e++) begin
      checks++;
      if (!entry_is(e, 0)) begin
        errors++;
        $display("FAIL int8_other[%0d]: lane0=%0d required 0", e, drained[e][0]);
      end
    end
  endtask

  task automatic test_int4();
    beat(2'd1, 1, 1'b1, {(A_W/8){8'hF1}}, {(B_W/8){8'h22}}, 1'b0);
    beat(2'd1, 2, 1'b1, {(A_W/8){8'hF1}}, {(B_W/8){8'h12}}, 1'b0);
    drain(0, -1);
    checks++;
    if (!entry_is(1, 0)) begin
      errors++;
      $display("FAIL int4_cancel: lane0=%0d required 0", drained[1][0]);
    end
    checks++;
    if (!entry_is(2, 32)) begin
      errors++;
      $display("FAIL int4_dot: lane0=%0d required 32", drained[2][0]);
    end
  endtask

  task automatic test_hazard();
    logic [A_W-1:0] a;
    logic [B_W-1:0] b;
    a = '0;
    b = '0;
    for (int l = 0; l < N_LANES; l++) a[l*B_W +: 8] = 8'd10;
    b[7:0] = 8'd1;
    for (int n = 0; n < 4; n++) beat(2'd0, 5, n == 0, a, b, 1'b0);
    drain(0, -1);
    checks++;
    if (!entry_is(5, 40)) begin
      errors++;
      $display("FAIL hazard_same: lane0=%0d required 40", drained[5][0]);
    end
    beat(2'd0, 5, 1'b1, a, b, 1'b0);
    beat(2'd0, 6, 1'b1, a, b, 1'b0);
    beat(2'd0, 5, 1'b0, a, b, 1'b0);
    beat(2'd0, 6, 1'b0, a, b, 1'b0);
    drain(0, -1);
    checks++;
    if (!entry_is(5, 20) || !entry_is(6, 20)) begin
      errors++;
      $display("FAIL hazard_interleave: e5=%0d e6=%0d required 20 20", drained[5][0], drained[6][0]);
    end
  endtask

  task automatic test_saturation();
    for (int n = 0; n < 20; n++) beat(2'd0, 3, n == 0, {(A_W/8){8'h7F}}, {(B_W/8){8'h7F}}, 1'b0);
    repeat (3) @(negedge clk);
    checks++;
    if (bus.sat_flag !== 1'b1) begin
      errors++;
      $display("FAIL sat_flag_set: sat_flag=%b required 1", bus.sat_flag);
    end
    drain(0, -1);
    checks++;
    if (!entry_is(3, 8388607)) begin
      errors++;
      $display("FAIL sat_value: lane0=%0d required 8388607", drained[3][0]);
    end
  endtask

  task automatic test_mode_err();
    logic [A_W-1:0] a;
    logic [B_W-1:0] b;
    rand_operands(a, b);
    beat(2'd2, 4, 1'b1, a, b, 1'b0);
    rand_operands(a, b);
    beat(2'd3, 4, 1'b0, a, b, 1'b0);
    checks++;
    if (bus.mode_err !== 1'b1) begin
      errors++;
      $display("FAIL mode_err_set: mode_err=%b required 1", bus.mode_err);
    end
    drain(0, -1);
    checks++;
    if (!entry_is(4, 0)) begin
      errors++;
      $display("FAIL mode_err_zero_dot: lane0=%0d required 0", drained[4][0]);
    end
  endtask

  task automatic test_backpressure();
    logic [A_W-1:0] a;
    logic [B_W-1:0] b;
    for (int e = 0; e < ACC_DEPTH; e++) begin
      rand_operands(a, b);
      beat(2'd0, e, 1'b1, a, b, 1'b0);
    end
    drain(1, -1);
    drain(0, -1);
    for (int e = 0; e < ACC_DEPTH; e++) begin
      checks++;
      if (!entry_is(e, 0)) begin
        errors++;
        $display("FAIL backpressure_cleared[%0d]: lane0=%0d required 0", e, drained[e][0]);
      end
    end
  endtask

  task automatic test_beat_with_drain();
    logic [A_W-1:0] a;
    logic [B_W-1:0] b;
    rand_operands(a, b);
    beat(2'd0, 8, 1'b1, a, b, 1'b0);
    rand_operands(a, b);
    beat(2'd1, 9, 1'b1, a, b, 1'b1);
    drain(2, -1);
  endtask

  task automatic test_random();
    logic [A_W-1:0] a;
    logic [B_W-1:0] b;
    logic [1:0]     m;
    int             r;
    for (int round = 0; round < 2; round++) begin
      for (int n = 0; n < 60; n++) begin
        r = int'($urandom_range(7, 0));
        if (r < 4)      m = 2'd0;
        else if (r < 7) m = 2'd1;
        else            m = 2'($urandom_range(3, 2));
        rand_operands(a, b);
        beat(m, int'($urandom_range(ACC_DEPTH - 1, 0)), ($urandom_range(2, 0) == 0), a, b, 1'b0);
        repeat ($urandom_range(2, 0)) @(negedge clk);
      end
      drain(2, -1);
    end
  endtask

  task automatic test_reset_mid_drain();
    logic [A_W-1:0] a;
    logic [B_W-1:0] b;
    for (int e = 0; e < ACC_DEPTH; e++) begin
      rand_operands(a, b);
      beat(2'd0, e, 1'b1, a, b, 1'b0);
    end
    drain(0, 7);
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_drain: out_valid=%b busy=%b required 0 0", bus.out_valid, bus.busy);
    end
    rst = 1'b0;
    model_clear();
    drain(0, -1);
    for (int e = 0; e < ACC_DEPTH; e++) begin
      checks++;
      if (!entry_is(e, 0)) begin
        errors++;
        $display("FAIL reset_cleared[%0d]: lane0=%0d required 0", e, drained[e][0]);
      end
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_mode   = 2'd0;
    bus.in_addr   = '0;
    bus.in_first  = 1'b0;
    bus.a_vec     = '0;
    bus.b_vec     = '0;
    bus.drain_req = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_int8_basic();
    test_int4();
    test_hazard();
    test_saturation();
    test_mode_err();
    test_backpressure();
    test_beat_with_drain();
    test_random();
    test_reset_mid_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_array_acc.md
Name: mac_array_acc

Overview:
- Parametrised successor to the 16-lane INT8/INT4 MAC array.
- N_LANES lanes each compute a signed dot product of a per-lane A vector against a shared B vector.
- Each lane accumulates results into an addressable ACC_DEPTH-entry partial-sum buffer (register-based, no latches), with saturation.
- Accumulated tiles are read out through a valid/ready drain port. Sits between the operand fetch unit and the output writeback.

Parameters:
- N_LANES, 16, number of parallel MAC lanes
- N_ELEM, 32, bytes per operand vector (INT8: N_ELEM products; INT4: 2*N_ELEM products)
- ACC_DEPTH, 16, partial-sum entries per lane (power of two, >=2)
- ACC_W, 24, signed accumulator width per entry
- AW, $clog2(ACC_DEPTH), entry address width (derived)

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock; reset is synchronous and active-high
- in_valid  in  1  operand beat valid
- in_ready  out  1  beat accepted when in_valid & in_ready
- in_mode  in  2  0=INT8, 1=INT4, 2/3 reserved
- in_addr  in  AW  target accumulator entry
- in_first  in  1  overwrite entry instead of adding
- a_vec  in  N_LANES*N_ELEM*8  lane l at bits [l*N_ELEM*8 +: N_ELEM*8]
- b_vec  in  N_ELEM*8  shared operand
- drain_req  in  1  pulse: request readout of all entries
- out_valid  out  1  drain data valid
- out_ready  in  1  downstream accepts
- out_addr  out  AW  entry index being drained
- out_data  out  N_LANES*ACC_W  lane l at [l*ACC_W +: ACC_W]
- sat_flag  out  1  sticky: any accumulation saturated since last drain
- mode_err  out  1  sticky: reserved mode beat accepted
- busy  out  1  state != IDLE or pipeline non-empty

Behaviour:
- Reset values:
  - Outputs: in_ready=0, out_valid=0, out_addr=0, out_data=0, sat_flag=0, mode_err=0, busy=0.
  - Internal state: all buffer entries=0, FSM=IDLE, pipeline valid bits=0.
  - Reset mid-drain or mid-accumulation aborts immediately; no partial output.
- FSM:
  - IDLE: in_ready=1. Accepted beat -> ACCUM. drain_req -> DRAIN_WAIT.
  - ACCUM: in_ready=1. drain_req -> DRAIN_WAIT, and in_ready drops the cycle after drain_req is seen.
  - DRAIN_WAIT: in_ready=0. Waits until both pipeline stages are empty, then -> DRAIN with out_addr=0.
  - DRAIN: out_valid=1 with the entry at out_addr.
    - On out_ready handshake: entry is cleared to 0 and out_addr increments.
    - Handshake at out_addr=ACC_DEPTH-1 -> IDLE; out_valid drops the next cycle.
    - Drain clears sat_flag and mode_err on the final handshake.
  - drain_req outside IDLE/ACCUM is ignored.
  - Beat and drain_req in the same IDLE/ACCUM cycle: the beat is accepted and included in the drain.
- Arithmetic per lane:
  - INT8: sum of N_ELEM signed 8x8 products.
  - INT4: each byte holds two signed nibbles; the low nibble pairs with the low nibble, high with high; 2*N_ELEM products are summed.
  - Reserved mode: the dot product is 0 and mode_err is set.
  - The dot product is computed at full width, then sign-extended.
  - Accumulate as new = (in_first ? 0 : old) + dot, saturated to [-2^(ACC_W-1), 2^(ACC_W-1)-1]; saturation sets sat_flag.
- Pipeline, 2 stages:
  - S1 registers the lane dot products plus addr/first/valid.
  - S2 performs read-add-saturate-write.
  - A beat accepted at edge k is visible in the buffer after edge k+2.
- Hazard: back-to-back beats to the same in_addr must forward the S2 result, so there are no lost updates at any in_addr sequence. in_ready is never deasserted for hazards.
- Drain output is registered. out_data and out_addr must be stable while out_valid & !out_ready.

Decomposition:
- Shared package mac_pkg holds:
  - the mode encoding constants MODE_INT8=0, MODE_INT4=1;
  - the FSM state typedef (IDLE, ACCUM, DRAIN_WAIT, DRAIN);
  - a function for the saturating add.
- One sub-module, mac_lane_dot: combinational N_ELEM-wide INT8/INT4 dot product per lane, instantiated N_LANES times.

Test Plan:
- INT8 basic:
  - Stimulus: all a bytes=2, b bytes=3, N_ELEM=32, addr 0, first=1; then drain.
  - Required: entry0 = 192 on every lane, entries 1..15 = 0, out_addr 0..15 in order.
- INT4:
  - Stimulus: a bytes=0xF1 (lo=1, hi=-1), b bytes=0x22 (lo=2, hi=2).
  - Required: dot = 32*(2-2) = 0. With b=0x12 instead: dot = 32*(2-1) = 32.
- Hazard:
  - Stimulus: 4 consecutive beats to addr 5, first on beat 1, dot=10 each.
  - Required: entry5 = 40 after drain. Interleaved addr 5,6,5,6 gives entries 5 and 6 = 20 each.
- Saturation:
  - Stimulus: ACC_W=24, repeated INT8 beats with a=b=0x7F (dot = 32*16129 = 516128) to one entry, 20 beats.
  - Required: entry = 8388607 and sat_flag=1. sat_flag clears after drain completes.
- Drain backpressure:
  - Stimulus: out_ready toggled 1,0,0,1 during drain.
  - Required: out_data/out_addr held during stalls, 16 handshakes total, in_ready=0 throughout drain, buffer all-zero afterwards.
- Reset mid-drain:
  - Stimulus: assert rst at out_addr=7.
  - Required: the next cycle shows out_valid=0, busy=0, and all entries read back 0 on a subsequent drain.
